// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and protocol constants for the PS/2 keyboard receiver
package ps2_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_t;
    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXTEND  = 8'hE0;
    localparam int         PS2_EXT_BIT = 7;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes ps2_clk/ps2_data into clk and flags ps2_clk falling edges
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (all flops preset to 1, the bus idle level)
//   i_ps2_clk  : asynchronous keyboard clock
//   i_ps2_data : asynchronous keyboard data
//   o_fall     : high for one cycle when the synchronized keyboard clock falls
//   o_data     : synchronized keyboard data, aligned with o_fall
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data
);
    logic r_clk_s1, r_clk_s2, r_clk_hist, r_dat_s1, r_dat_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_clk_s1, r_clk_s2, r_clk_hist, r_dat_s1, r_dat_s2} <= 5'b11111;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_dat_s1   <= i_ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign o_fall = r_clk_hist & ~r_clk_s2;
    assign o_data = r_dat_s2;
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 frame receiver with make/break/extended key tracking
//   ram_clock     : sole clock, rising edge
//   reset         : synchronous active-high reset
//   ps2_clk       : asynchronous keyboard clock, idle high
//   ps2_data      : asynchronous keyboard data, idle high
//   keypress_data : code of the held key ({ext, byte[6:0]} for extended keys), 0 when none
//   scan_valid    : one-cycle pulse per good byte
//   scan_byte     : last good byte
//   frame_error   : one-cycle pulse per discarded frame
// Optional PS2_TIMEOUT_EN: abort a frame stalled for TIMEOUT_CYCLES cycles.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int KEYPRESS_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES      = 50000
) (
    input  logic                           ram_clock,
    input  logic                           reset,
    input  logic                           ps2_clk,
    input  logic                           ps2_data,
    output logic [KEYPRESS_DATA_WIDTH-1:0] keypress_data,
    output logic                           scan_valid,
    output logic [7:0]                     scan_byte,
    output logic                           frame_error
);
    ps2_state_t r_state, w_next;
    logic [2:0] r_cnt;
    logic [7:0] r_shift, r_key, r_scan_byte, w_code;
    logic       r_parity, r_ext, r_brk, r_valid, r_err;
    logic       w_fall, w_data, w_stop, w_good, w_bad, w_timeout;

    ps2_sync_edge u_sync (
        .clk        (ram_clock),
        .rst        (reset),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

`ifdef PS2_TIMEOUT_EN
    logic [31:0] r_tmo;

    always_ff @(posedge ram_clock) begin
        if (reset) r_tmo <= '0;
        else       r_tmo <= (w_fall || r_state == S_IDLE) ? '0 : r_tmo + 32'd1;
    end

    assign w_timeout = (r_state != S_IDLE) && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Good frame: stop bit high and odd parity over data plus parity bit
    assign w_stop = w_fall && (r_state == S_STOP);
    assign w_good = w_stop && w_data && (^{r_parity, r_shift});
    assign w_bad  = (w_stop && !w_good) || w_timeout;
    assign w_code = r_ext ? (r_shift | (8'd1 << PS2_EXT_BIT)) : r_shift;

    always_comb begin
        w_next = r_state;
        if (w_timeout)  w_next = S_IDLE;
        else if (w_fall) begin
            case (r_state)
                S_IDLE:   w_next = w_data ? S_IDLE : S_DATA;
                S_DATA:   w_next = (r_cnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: w_next = S_STOP;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ram_clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key       <= '0;
            r_scan_byte <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_good;
            r_err   <= w_bad;
            if (w_fall && r_state == S_IDLE) r_cnt <= '0;
            if (w_fall && r_state == S_DATA) begin
                r_shift <= {w_data, r_shift[7:1]};
                r_cnt   <= r_cnt + 3'd1;
            end
            if (w_fall && r_state == S_PARITY) r_parity <= w_data;
            if (w_bad) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
            if (w_good) begin
                r_scan_byte <= r_shift;
                if (r_shift == PS2_EXTEND)     r_ext <= 1'b1;
                else if (r_shift == PS2_BREAK) r_brk <= 1'b1;
                else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    // Release only clears the key it names; a stale release is ignored
                    if (!r_brk)               r_key <= w_code;
                    else if (w_code == r_key) r_key <= '0;
                end
            end
        end
    end

    assign keypress_data = KEYPRESS_DATA_WIDTH'(r_key);
    assign scan_valid    = r_valid;
    assign scan_byte     = r_scan_byte;
    assign frame_error   = r_err;
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed self-checking bench for ps2_keyboard
module tb_ps2_keyboard;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] keypress_data;
    logic       scan_valid;
    logic [7:0] scan_byte;
    logic       frame_error;

    int n_chk = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [7:0] last_byte = 8'h00;
    logic [9:0] key_at_valid = 10'h000;
    time t_fall = 0;
    time t_err = 0;

    always #5 clk = ~clk;

    ps2_keyboard #(.KEYPRESS_DATA_WIDTH(10), .TIMEOUT_CYCLES(100)) dut (
        .ram_clock     (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .keypress_data (keypress_data),
        .scan_valid    (scan_valid),
        .scan_byte     (scan_byte),
        .frame_error   (frame_error)
    );

    always @(negedge clk) begin
        if (scan_valid) begin
            n_valid++;
            last_byte = scan_byte;
            key_at_valid = keypress_data;
        end
        if (frame_error) begin
            n_err++;
            t_err = $time;
        end
    end

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = b[i];
            repeat (4) @(posedge clk);
            #1 ps2_clk = 1'b0;
            t_fall = $time;
            repeat (8) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (4) @(posedge clk);
        end
        #1 ps2_data = 1'b1;
    endtask

    // bad_par flips the odd parity bit; stop is the stop-bit value
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        send_bits({stop, (~^d) ^ bad_par, d, 1'b0}, 11);
        repeat (6) @(posedge clk);
    endtask

    task automatic good(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_key(input string name, input logic [9:0] exp);
        n_chk++;
        if (keypress_data !== exp) $display("FAIL %s: keypress_data=%h expected %h", name, keypress_data, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        chk_key("reset_key", 10'h000);
        n_chk++;
        if (scan_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", scan_valid); else n_pass++;
        n_chk++;
        if (scan_byte !== 8'h00) $display("FAIL reset_byte: got %h expected 00", scan_byte); else n_pass++;
        n_chk++;
        if (frame_error !== 1'b0) $display("FAIL reset_err: got %b expected 0", frame_error); else n_pass++;
    endtask

    task automatic test_make();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        good(8'h1C);
        n_chk++;
        if (n_valid - v0 !== 1) $display("FAIL make_pulses: got %0d expected 1", n_valid - v0); else n_pass++;
        n_chk++;
        if (last_byte !== 8'h1C) $display("FAIL make_byte: got %h expected 1c", last_byte); else n_pass++;
        n_chk++;
        if (key_at_valid !== 10'h01C) $display("FAIL make_key_same_cycle: got %h expected 01c", key_at_valid); else n_pass++;
        chk_key("make_key", 10'h01C);
        n_chk++;
        if (n_err - e0 !== 0) $display("FAIL make_err: got %0d expected 0", n_err - e0); else n_pass++;
    endtask

    task automatic test_break();
        int v0;
        v0 = n_valid;
        good(8'hF0);
        chk_key("break_prefix", 10'h01C);
        good(8'h1C);
        chk_key("break_release", 10'h000);
        n_chk++;
        if (key_at_valid !== 10'h000) $display("FAIL break_same_cycle: got %h expected 000", key_at_valid); else n_pass++;
        n_chk++;
        if (n_valid - v0 !== 2) $display("FAIL break_pulses: got %0d expected 2", n_valid - v0); else n_pass++;
    endtask

    task automatic test_extended();
        good(8'hE0);
        chk_key("ext_prefix", 10'h000);
        good(8'h75);
        chk_key("ext_make", 10'h0F5);
        good(8'hE0);
        chk_key("ext_prefix2", 10'h0F5);
        good(8'hF0);
        chk_key("ext_break_prefix", 10'h0F5);
        good(8'h75);
        chk_key("ext_release", 10'h000);
    endtask

    task automatic test_mismatch();
        good(8'h1C);
        good(8'h32);
        chk_key("last_make_wins", 10'h032);
        good(8'h32);
        chk_key("repeat_make", 10'h032);
        good(8'hF0);
        good(8'h1C);
        chk_key("mismatch_release", 10'h032);
        good(8'h1C);
        chk_key("flags_cleared", 10'h01C);
    endtask

    task automatic test_bad_frames();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        n_chk++;
        if (n_err - e0 !== 2) $display("FAIL bad_err_pulses: got %0d expected 2", n_err - e0); else n_pass++;
        n_chk++;
        if (n_valid - v0 !== 0) $display("FAIL bad_valid: got %0d expected 0", n_valid - v0); else n_pass++;
        chk_key("bad_key", 10'h01C);
        n_chk++;
        if (scan_byte !== 8'h1C) $display("FAIL bad_scan_byte: got %h expected 1c", scan_byte); else n_pass++;
        good(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b1);
        good(8'h1C);
        chk_key("bad_clears_break", 10'h01C);
    endtask

    task automatic test_noise();
        int e0;
        e0 = n_err;
        send_bits(11'h7FF, 1);
        repeat (6) @(posedge clk);
        n_chk++;
        if (n_err - e0 !== 0) $display("FAIL noise_err: got %0d expected 0", n_err - e0); else n_pass++;
        good(8'h29);
        chk_key("noise_then_frame", 10'h029);
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_bits({1'b1, 1'b1, 8'h4D, 1'b0}, 5);
        do_reset();
        repeat (20) @(posedge clk);
        n_chk++;
        if ((n_valid - v0) + (n_err - e0) !== 0) $display("FAIL reset_mid_pulses: got %0d expected 0", (n_valid - v0) + (n_err - e0)); else n_pass++;
        chk_key("reset_mid_key", 10'h000);
        good(8'h29);
        chk_key("reset_mid_next", 10'h029);
        n_chk++;
        if (last_byte !== 8'h29) $display("FAIL reset_mid_byte: got %h expected 29", last_byte); else n_pass++;
    endtask

    task automatic test_stall();
        int e0;
        longint lat;
        e0 = n_err;
        send_bits({1'b1, 1'b1, 8'h4D, 1'b0}, 5);
`ifdef PS2_TIMEOUT_EN
        repeat (150) @(posedge clk);
        n_chk++;
        if (n_err - e0 !== 1) $display("FAIL timeout_err: got %0d expected 1", n_err - e0); else n_pass++;
        lat = longint'((t_err - t_fall) / 10);
        n_chk++;
        if (lat < 98 || lat > 106) $display("FAIL timeout_latency: got %0d expected ~100", lat); else n_pass++;
`else
        repeat (300) @(posedge clk);
        n_chk++;
        if (n_err - e0 !== 0) $display("FAIL stall_err: got %0d expected 0", n_err - e0); else n_pass++;
        do_reset();
`endif
        good(8'h29);
        n_chk++;
        if (last_byte !== 8'h29) $display("FAIL after_stall_byte: got %h expected 29", last_byte); else n_pass++;
        chk_key("after_stall_key", 10'h029);
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_mismatch();
        test_bad_frames();
        test_noise();
        test_reset_mid();
        test_stall();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
